// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and its helpers.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    // Must stay identical to the decode unit's jump output encoding.
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector between the EX load and the ID consumer; purely combinational.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational enables/flushes,
// registered dmem wait FSM with timeout trap and stall/redirect performance counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_branch_taken,
    input  logic [1:0]           ex_jump,
    input  logic                 mem_req,
    input  logic                 dmem_ready,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_write,
    output logic                 id_ex_flush,
    output logic                 ex_mem_write,
    output logic                 mem_wb_flush,
    output logic                 redirect,
    output logic                 bus_error,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    ctrl_state_e      state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             bus_error_q, bus_error_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic load_use;
    logic redirect_req;
    logic freeze;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    assign redirect_req = ex_branch_taken || (ex_jump != JUMP_NONE);

    always_comb begin
        freeze = 1'b0;
        unique case (state_q)
            RUN:      freeze = mem_req && !dmem_ready;
            MEM_WAIT: freeze = !dmem_ready;
            ERROR:    freeze = 1'b1;
            default:  freeze = 1'b1;
        endcase
    end

    // Priority freeze > redirect > load-use: a held redirect simply waits out a freeze
    // because EX does not advance, and a redirect kills the wrong-path ID instruction.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        redirect     = 1'b0;
        if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (redirect_req) begin
            redirect    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // mem_req is deliberately ignored in MEM_WAIT: the access is already outstanding.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bus_error_d = bus_error_q;
        unique case (state_q)
            RUN: begin
                if (mem_req && !dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d     = ERROR;
                    bus_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERROR: begin
                bus_error_d = 1'b1;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus_error    = bus_error_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline. Sits beside the decode control logic.
- Consumes hazard-relevant control fields from the ID, EX and MEM pipeline registers, plus the data-memory ready handshake.
- Drives the PC/pipeline-register enables and flushes.
- Tracks data-memory wait states with a small FSM, including a timeout/error trap, and keeps stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, max consecutive dmem_ready-low cycles tolerated before the error trap; legal range 1..255.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the EX instruction
- ex_branch_taken  in  1  EX branch resolved taken (branch & ALU compare true)
- ex_jump  in  2  EX jump class: 00 none, 01 JAL, 10 JALR
- mem_req  in  1  MEM-stage instruction accesses dmem (mem_read | mem_write)
- dmem_ready  in  1  dmem completes the access this cycle
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID becomes a bubble
- id_ex_write  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX becomes a bubble
- ex_mem_write  out  1  EX/MEM register enable
- mem_wb_flush  out  1  MEM/WB receives a bubble
- redirect  out  1  PC mux selects the EX target
- bus_error  out  1  sticky dmem timeout flag
- stall_cycles  out  CNT_W  count of cycles with pc_write=0
- flush_count  out  CNT_W  count of redirect events

Behaviour:
- Reset (async, rst_n=0): FSM=RUN, wait_cnt=0, bus_error=0, both counters=0. With all inputs at 0, the outputs settle to pc_write=if_id_write=id_ex_write=ex_mem_write=1 and all flushes/redirect=0.
- Control outputs are combinational from the inputs and the FSM state (0-cycle latency). The FSM, wait_cnt, bus_error and the counters are registered.
- freeze = (state==RUN & mem_req & ~dmem_ready) | (state==MEM_WAIT & ~dmem_ready) | (state==ERROR).
- freeze effect: pc_write, if_id_write, id_ex_write and ex_mem_write all = 0; mem_wb_flush=1; redirect=0; if_id_flush=id_ex_flush=0.
- redirect_req = ex_branch_taken | (ex_jump != 00).
  - When it fires and there is no freeze: redirect=1, if_id_flush=1, id_ex_flush=1, pc_write=1.
  - A redirect_req held while frozen stays pending naturally, because EX holds. It takes effect on the first unfrozen cycle and is counted once.
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - When it fires and there is no freeze and no redirect_req: pc_write=0, if_id_write=0, id_ex_flush=1.
- Priority: freeze > redirect_req > load_use. A redirect masks load_use because the ID instruction is wrong-path.
- FSM states RUN, MEM_WAIT, ERROR:
  - RUN: if mem_req & ~dmem_ready, go to MEM_WAIT with wait_cnt=1; otherwise stay.
  - MEM_WAIT: if dmem_ready, go to RUN with wait_cnt=0. Else if wait_cnt == MEM_TIMEOUT, go to ERROR and set bus_error=1. Else wait_cnt+1.
  - ERROR: terminal until reset. Pipeline frozen, bus_error held at 1.
- mem_req dropping while in MEM_WAIT is a protocol violation. The block keeps waiting for dmem_ready regardless.
- stall_cycles increments every cycle pc_write=0. flush_count increments every cycle redirect=1. Both wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-wait or in ERROR: immediate return to RUN, counters cleared, bus_error cleared.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the FSM state enum (RUN, MEM_WAIT, ERROR);
  - jump encoding constants JUMP_NONE=00, JUMP_JAL=01, JUMP_JALR=10, identical to the decode unit's jump output;
  - the register-index width constant (5).
- Sub-module hazard_detect (combinational) takes the ID/EX register fields and produces load_use. It is reused later by the forwarding unit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_write=0, if_id_write=0, id_ex_flush=1, stall_cycles +1. Repeat with ex_rd=0 -> no stall.
- Redirect vs load-use: ex_jump=10 together with the load_use condition -> redirect=1, if_id_flush=id_ex_flush=1, pc_write=1, flush_count +1.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles then 1 -> freeze for exactly 3 cycles, mem_wb_flush=1 during them, state returns to RUN on cycle 4, stall_cycles +3.
- Redirect during freeze: ex_branch_taken=1 held across a 2-cycle wait -> redirect=0 while frozen, redirect=1 on the first ready cycle, flush_count +1 only.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> bus_error=1 after the 5th wait cycle, pipeline frozen permanently. Pull rst_n low mid-ERROR -> all outputs return to reset values immediately.
- Counter wrap: CNT_W=4, force 17 stall cycles -> stall_cycles=1.
